// File: rtl/segment_unit.sv
// Segment register file with override latch, one-stage physical-address pipeline
// and the interrupt shadow that follows a stack-segment write.
module segment_unit #(
    parameter int unsigned      SEG_W    = 16,
    parameter int unsigned      NUM_SEG  = 4,
    parameter int unsigned      SHIFT    = 4,
    parameter int unsigned      ADDR_W   = 20,
    parameter int unsigned      SS_IDX   = 2,
    parameter logic [SEG_W-1:0] CS_RESET = '0,
    localparam int unsigned     SEL_W    = $clog2(NUM_SEG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [SEL_W-1:0]  seg_sel,
    input  logic [SEG_W-1:0]  seg_in,
    input  logic [SEL_W-1:0]  rd_sel,
    output logic [SEG_W-1:0]  rd_data,
    input  logic              ovr_valid,
    input  logic [SEL_W-1:0]  ovr_sel,
    input  logic              instr_done,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [SEL_W-1:0]  req_seg,
    input  logic [SEG_W-1:0]  req_offset,
    input  logic              req_no_ovr,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [ADDR_W-1:0] resp_addr,
    output logic [SEL_W-1:0]  resp_seg,
    output logic              resp_wrap,
    output logic              irq_inhibit
);

    localparam logic [SEL_W-1:0] SS_SEL = SEL_W'(SS_IDX);

    logic [SEG_W-1:0]  seg_q [NUM_SEG];
    logic [SEG_W-1:0]  seg_d [NUM_SEG];
    logic              ovr_pend_q, ovr_pend_d;
    logic [SEL_W-1:0]  ovr_sel_q, ovr_sel_d;
    logic              resp_valid_q, resp_valid_d;
    logic [ADDR_W-1:0] resp_addr_q, resp_addr_d;
    logic [SEL_W-1:0]  resp_seg_q, resp_seg_d;
    logic              resp_wrap_q, resp_wrap_d;
    logic              irq_q, irq_d;

    logic              accept;
    logic [SEL_W-1:0]  eff_sel;
    logic [SEG_W-1:0]  eff_val;
    logic [ADDR_W:0]   seg_ext;
    logic [ADDR_W:0]   off_ext;
    logic [ADDR_W:0]   sum;

    assign rd_data     = seg_q[rd_sel];
    assign req_ready   = !resp_valid_q || resp_ready;
    assign accept      = req_valid && req_ready;
    assign resp_valid  = resp_valid_q;
    assign resp_addr   = resp_addr_q;
    assign resp_seg    = resp_seg_q;
    assign resp_wrap   = resp_wrap_q;
    assign irq_inhibit = irq_q;

    always_comb begin
        seg_d = seg_q;
        if (we) begin
            seg_d[seg_sel] = seg_in;
        end
    end

    // A prefix decoded in the same cycle as the request only applies from the next cycle.
    always_comb begin
        ovr_pend_d = ovr_pend_q;
        ovr_sel_d  = ovr_sel_q;
        if (ovr_valid) begin
            ovr_pend_d = 1'b1;
            ovr_sel_d  = ovr_sel;
        end else if (instr_done) begin
            ovr_pend_d = 1'b0;
        end
    end

    always_comb begin
        eff_sel = (ovr_pend_q && !req_no_ovr) ? ovr_sel_q : req_seg;
        eff_val = (we && (seg_sel == eff_sel)) ? seg_in : seg_q[eff_sel];
        seg_ext = '0;
        seg_ext[SEG_W-1:0] = eff_val;
        seg_ext = seg_ext << SHIFT;
        off_ext = '0;
        off_ext[SEG_W-1:0] = req_offset;
        sum = seg_ext + off_ext;
    end

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_addr_d  = resp_addr_q;
        resp_seg_d   = resp_seg_q;
        resp_wrap_d  = resp_wrap_q;
        if (accept) begin
            resp_valid_d = 1'b1;
            resp_addr_d  = sum[ADDR_W-1:0];
            resp_seg_d   = eff_sel;
            resp_wrap_d  = sum[ADDR_W];
        end else if (resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    // An SS write takes priority, so a retire in the write cycle never clears the shadow.
    always_comb begin
        irq_d = irq_q;
        if (we && (seg_sel == SS_SEL)) begin
            irq_d = 1'b1;
        end else if (instr_done) begin
            irq_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_SEG; i++) begin
                seg_q[i] <= (i == 0) ? CS_RESET : '0;
            end
            ovr_pend_q   <= 1'b0;
            ovr_sel_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_addr_q  <= '0;
            resp_seg_q   <= '0;
            resp_wrap_q  <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            ovr_pend_q   <= ovr_pend_d;
            ovr_sel_q    <= ovr_sel_d;
            resp_valid_q <= resp_valid_d;
            resp_addr_q  <= resp_addr_d;
            resp_seg_q   <= resp_seg_d;
            resp_wrap_q  <= resp_wrap_d;
            irq_q        <= irq_d;
        end
    end

endmodule

// File: tb/tb_segment_unit.sv
// Scoreboard bench for segment_unit: directed scenarios followed by a random stream.
module tb_segment_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [1:0]  seg_sel;
    logic [15:0] seg_in;
    logic [1:0]  rd_sel;
    logic [15:0] rd_data;
    logic        ovr_valid;
    logic [1:0]  ovr_sel;
    logic        instr_done;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_seg;
    logic [15:0] req_offset;
    logic        req_no_ovr;
    logic        resp_valid;
    logic        resp_ready;
    logic [19:0] resp_addr;
    logic [1:0]  resp_seg;
    logic        resp_wrap;
    logic        irq_inhibit;

    typedef struct packed {
        logic [19:0] addr;
        logic [1:0]  seg;
        logic        wrap;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_seg [4];
    logic        m_pend;
    logic [1:0]  m_osel;
    logic        m_irq;
    logic        m_rv;
    int          n_checks = 0;
    int          n_fail = 0;

    segment_unit #(.SEG_W(16), .NUM_SEG(4), .SHIFT(4), .ADDR_W(20), .SS_IDX(2),
                   .CS_RESET(16'hF000)) dut (
        .clk(clk), .rst(rst), .we(we), .seg_sel(seg_sel), .seg_in(seg_in),
        .rd_sel(rd_sel), .rd_data(rd_data), .ovr_valid(ovr_valid), .ovr_sel(ovr_sel),
        .instr_done(instr_done), .req_valid(req_valid), .req_ready(req_ready),
        .req_seg(req_seg), .req_offset(req_offset), .req_no_ovr(req_no_ovr),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_addr(resp_addr),
        .resp_seg(resp_seg), .resp_wrap(resp_wrap), .irq_inhibit(irq_inhibit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_seg[0] = 16'hF000;
        m_seg[1] = '0;
        m_seg[2] = '0;
        m_seg[3] = '0;
        m_pend = 1'b0;
        m_osel = '0;
        m_irq = 1'b0;
        m_rv = 1'b0;
        sb.delete();
    endtask

    // Inputs are set after a rising edge; checks and model update run at the falling edge.
    task automatic tick();
        logic        acc;
        logic [1:0]  es;
        logic [15:0] sv;
        int unsigned full;
        @(negedge clk);
        check("rd_data", 32'(rd_data), 32'(m_seg[rd_sel]));
        check("irq_inhibit", 32'(irq_inhibit), 32'(m_irq));
        check("resp_valid", 32'(resp_valid), 32'(m_rv));
        check("req_ready", 32'(req_ready), 32'(!m_rv || resp_ready));
        if (m_rv) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 32'(sb.size()), 32'd1);
            end else begin
                check("resp_addr", 32'(resp_addr), 32'(sb[0].addr));
                check("resp_seg", 32'(resp_seg), 32'(sb[0].seg));
                check("resp_wrap", 32'(resp_wrap), 32'(sb[0].wrap));
                if (resp_ready) void'(sb.pop_front());
            end
        end
        acc = req_valid && (!m_rv || resp_ready);
        if (acc) begin
            es = (m_pend && !req_no_ovr) ? m_osel : req_seg;
            sv = (we && seg_sel == es) ? seg_in : m_seg[es];
            full = 32'(sv) * 16 + 32'(req_offset);
            sb.push_back('{addr: full[19:0], seg: es, wrap: full[20]});
        end
        m_rv = acc || (m_rv && !resp_ready);
        if (we && seg_sel == 2'd2) m_irq = 1'b1;
        else if (instr_done) m_irq = 1'b0;
        if (we) m_seg[seg_sel] = seg_in;
        if (ovr_valid) begin
            m_pend = 1'b1;
            m_osel = ovr_sel;
        end else if (instr_done) begin
            m_pend = 1'b0;
        end
        @(posedge clk);
        #1;
        we = 1'b0;
        ovr_valid = 1'b0;
        instr_done = 1'b0;
        req_valid = 1'b0;
        req_no_ovr = 1'b0;
    endtask

    task automatic set_req(input logic [1:0] s, input logic [15:0] off, input logic no_ovr);
        req_valid = 1'b1;
        req_seg = s;
        req_offset = off;
        req_no_ovr = no_ovr;
    endtask

    task automatic write_seg(input logic [1:0] s, input logic [15:0] v);
        we = 1'b1;
        seg_sel = s;
        seg_in = v;
    endtask

    initial begin
        rst = 1'b1;
        we = 0; seg_sel = 0; seg_in = 0; rd_sel = 0;
        ovr_valid = 0; ovr_sel = 0; instr_done = 0;
        req_valid = 0; req_seg = 0; req_offset = 0; req_no_ovr = 0; resp_ready = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset mid-operation with a stalled response and an armed shadow
        resp_ready = 1'b0;
        write_seg(2'd2, 16'h0100);
        set_req(2'd0, 16'h0004, 1'b0);
        tick();
        check("t1_pre_valid", 32'(resp_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("t1_resp_valid", 32'(resp_valid), 32'd0);
        check("t1_resp_addr", 32'(resp_addr), 32'd0);
        check("t1_resp_seg", 32'(resp_seg), 32'd0);
        check("t1_resp_wrap", 32'(resp_wrap), 32'd0);
        check("t1_irq", 32'(irq_inhibit), 32'd0);
        check("t1_req_ready", 32'(req_ready), 32'd1);
        check("t1_cs_reset", 32'(rd_data), 32'h0000F000);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        resp_ready = 1'b1;
        rd_sel = 2'd2;
        tick();

        // Basic translation, one-cycle latency
        write_seg(2'd1, 16'h1234);
        tick();
        set_req(2'd1, 16'h0005, 1'b0);
        tick();
        check("t2_valid", 32'(resp_valid), 32'd1);
        check("t2_addr", 32'(resp_addr), 32'h12345);
        check("t2_seg", 32'(resp_seg), 32'd1);
        check("t2_wrap", 32'(resp_wrap), 32'd0);
        tick();

        // Override, override bypass, override cleared by retire
        write_seg(2'd3, 16'h2000);
        tick();
        ovr_valid = 1'b1;
        ovr_sel = 2'd3;
        tick();
        set_req(2'd1, 16'h0010, 1'b0);
        tick();
        check("t3_ovr_addr", 32'(resp_addr), 32'h20010);
        check("t3_ovr_seg", 32'(resp_seg), 32'd3);
        set_req(2'd1, 16'h0010, 1'b1);
        tick();
        check("t3_noovr_addr", 32'(resp_addr), 32'h12350);
        set_req(2'd1, 16'h0010, 1'b0);
        tick();
        check("t3_persist_addr", 32'(resp_addr), 32'h20010);
        instr_done = 1'b1;
        tick();
        set_req(2'd1, 16'h0010, 1'b0);
        tick();
        check("t3_cleared_seg", 32'(resp_seg), 32'd1);
        tick();

        // Backpressure: result held, no loss or duplication
        resp_ready = 1'b0;
        set_req(2'd1, 16'h0100, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_req(2'd1, 16'h0200, 1'b0);
            check("t4_stall_ready", 32'(req_ready), 32'd0);
            check("t4_stall_addr", 32'(resp_addr), 32'h12440);
            tick();
        end
        resp_ready = 1'b1;
        set_req(2'd1, 16'h0200, 1'b0);
        tick();
        check("t4_next_addr", 32'(resp_addr), 32'h12540);
        tick();
        check("t4_drained", 32'(resp_valid), 32'd0);

        // SS write forwarded into the same-cycle request; shadow survives retire in that cycle
        write_seg(2'd2, 16'hFFFF);
        set_req(2'd2, 16'h0010, 1'b0);
        instr_done = 1'b1;
        tick();
        check("t5_addr", 32'(resp_addr), 32'h00000);
        check("t5_wrap", 32'(resp_wrap), 32'd1);
        check("t5_irq_set", 32'(irq_inhibit), 32'd1);
        tick();
        check("t5_irq_hold", 32'(irq_inhibit), 32'd1);
        instr_done = 1'b1;
        tick();
        check("t5_irq_clear", 32'(irq_inhibit), 32'd0);

        // Random stream
        for (int i = 0; i < 4000; i++) begin
            rd_sel = 2'($urandom_range(0, 3));
            resp_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 3) == 0) write_seg(2'($urandom_range(0, 3)), 16'($urandom));
            if ($urandom_range(0, 9) == 0) begin
                ovr_valid = 1'b1;
                ovr_sel = 2'($urandom_range(0, 3));
            end
            instr_done = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 9) < 7)
                set_req(2'($urandom_range(0, 3)), 16'($urandom), ($urandom_range(0, 9) < 3));
            tick();
        end
        resp_ready = 1'b1;
        repeat (3) tick();
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
